// File: rtl/cdc_2phase_dst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cdc_2phase_dst_fifo
// Brief    : Destination half of a two-phase CDC handshake with a local FIFO
//            so the crossing acknowledges on store, not on consume.
// Revision : 1.0
// ============================================================================
module cdc_2phase_dst_fifo #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned Depth      = 2,
    parameter int unsigned SyncStages = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         async_req_i,
    output logic                         async_ack_o,
    input  logic [DataWidth-1:0]         async_data_i,
    output logic [DataWidth-1:0]         data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(Depth+1)-1:0]   usage_o
);

    localparam int unsigned c_PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned c_CNT_W = $clog2(Depth + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(Depth - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(Depth);

    logic [SyncStages-1:0]  r_sync;
    logic                   r_ack;
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [DataWidth-1:0]   r_mem [Depth];

    logic w_req_s;
    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign w_req_s = r_sync[SyncStages-1];
    // Full comes from the registered count only: a pop never frees room for a push in the same cycle.
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_valid = (r_count != '0);
    assign w_push  = (w_req_s != r_ack) && !w_full;
    assign w_pop   = w_valid && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], async_req_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_ack  <= ~r_ack;
                r_wptr <= f_next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next_ptr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is intentionally left unreset; an empty FIFO masks the head instead.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= async_data_i;
        end
    end

    assign async_ack_o = r_ack;
    assign valid_o     = w_valid;
    assign data_o      = w_valid ? r_mem[r_rptr] : '0;
    assign usage_o     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cdc_2phase_dst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_2phase_dst_fifo
// Brief    : Directed bench for cdc_2phase_dst_fifo (Depth=2/Sync=2 and Depth=3/Sync=3).
// Revision : 1.0
// ============================================================================
module tb_cdc_2phase_dst_fifo;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    logic        a_req, a_ack, a_valid, a_ready;
    logic [31:0] a_data_in, a_data;
    logic [1:0]  a_usage;

    logic        b_req, b_ack, b_valid, b_ready;
    logic [31:0] b_data_in, b_data;
    logic [1:0]  b_usage;

    logic        b_rnd = 1'b0;
    logic [31:0] rec_b [$];

    always #5 clk = ~clk;

    cdc_2phase_dst_fifo #(.DataWidth(32), .Depth(2), .SyncStages(2)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .async_req_i(a_req), .async_ack_o(a_ack), .async_data_i(a_data_in),
        .data_o(a_data), .valid_o(a_valid), .ready_i(a_ready), .usage_o(a_usage)
    );

    cdc_2phase_dst_fifo #(.DataWidth(32), .Depth(3), .SyncStages(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .async_req_i(b_req), .async_ack_o(b_ack), .async_data_i(b_data_in),
        .data_o(b_data), .valid_o(b_valid), .ready_i(b_ready), .usage_o(b_usage)
    );

    // Record every item the consumer of instance B accepts.
    always @(posedge clk) begin
        if (!rst && b_valid && b_ready) rec_b.push_back(b_data);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_a(input logic [31:0] d);
        int n = 0;
        a_data_in = d;
        a_req     = ~a_req;
        while (a_ack !== a_req && n < 50) begin
            tick(1);
            n++;
        end
        chk("a_ack_timeout", 64'(a_ack === a_req), 64'd1);
    endtask

    task automatic send_b(input logic [31:0] d);
        int n = 0;
        b_data_in = d;
        b_req     = ~b_req;
        while (b_ack !== b_req && n < 200) begin
            if (b_rnd) b_ready = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        if (b_ack !== b_req) chk("b_ack_timeout", 64'(b_ack), 64'(b_req));
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_ready = 1'b0; a_data_in = '0;
        b_req = 1'b0; b_ready = 1'b0; b_data_in = '0;
        #1;
        chk("rst_ack",   64'(a_ack),   64'd0);
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_data",  64'(a_data),  64'd0);
        chk("rst_usage", 64'(a_usage), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        // Single item latency, SyncStages=2
        a_ready = 1'b1; a_data_in = 32'hA5A5_0001; a_req = 1'b1;
        tick(1);
        chk("lat_e0_valid", 64'(a_valid), 64'd0);
        tick(1);
        chk("lat_e1_ack", 64'(a_ack), 64'd0);
        chk("lat_e1_valid", 64'(a_valid), 64'd0);
        tick(1);
        chk("lat_e2_ack", 64'(a_ack), 64'd1);
        chk("lat_e2_valid", 64'(a_valid), 64'd1);
        chk("lat_e2_data", 64'(a_data), 64'hA5A5_0001);
        tick(1);
        chk("lat_e3_valid", 64'(a_valid), 64'd0);
        chk("lat_e3_usage", 64'(a_usage), 64'd0);

        // Back-pressure, full with pop then deferred push (2->1->2)
        a_ready = 1'b0;
        send_a(32'h11);
        send_a(32'h22);
        chk("bp_usage2", 64'(a_usage), 64'd2);
        a_data_in = 32'h33; a_req = ~a_req;
        tick(6);
        chk("bp_ack_held", 64'(a_ack), 64'd1);
        chk("bp_usage_held", 64'(a_usage), 64'd2);
        chk("bp_head", 64'(a_data), 64'h11);
        a_ready = 1'b1;
        tick(1);
        a_ready = 1'b0;
        chk("bp_pop_usage1", 64'(a_usage), 64'd1);
        chk("bp_pop_ack_held", 64'(a_ack), 64'd1);
        tick(1);
        chk("bp_push_usage2", 64'(a_usage), 64'd2);
        chk("bp_push_ack", 64'(a_ack), 64'd0);
        chk("bp_head2", 64'(a_data), 64'h22);
        a_ready = 1'b1;
        tick(1);
        chk("bp_head3", 64'(a_data), 64'h33);
        chk("bp_usage_drain", 64'(a_usage), 64'd1);
        tick(1);
        chk("bp_empty", 64'(a_valid), 64'd0);

        // Reset while holding two items
        a_ready = 1'b0;
        send_a(32'h44);
        send_a(32'h55);
        chk("mr_usage2", 64'(a_usage), 64'd2);
        #2;
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
        #1;
        chk("mr_valid", 64'(a_valid), 64'd0);
        chk("mr_usage", 64'(a_usage), 64'd0);
        chk("mr_ack",   64'(a_ack),   64'd0);
        chk("mr_data",  64'(a_data),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        send_a(32'h66);
        tick(1);
        chk("mr_fresh_usage", 64'(a_usage), 64'd1);
        chk("mr_fresh_data", 64'(a_data), 64'h66);
        a_ready = 1'b1;
        tick(1);
        chk("mr_fresh_drain", 64'(a_valid), 64'd0);

        // Latency with SyncStages=3
        b_ready = 1'b1; b_data_in = 32'hB0; b_req = 1'b1;
        tick(3);
        chk("s3_e2_ack", 64'(b_ack), 64'd0);
        chk("s3_e2_valid", 64'(b_valid), 64'd0);
        tick(1);
        chk("s3_e3_ack", 64'(b_ack), 64'd1);
        chk("s3_e3_valid", 64'(b_valid), 64'd1);
        chk("s3_e3_data", 64'(b_data), 64'hB0);
        tick(1);
        chk("s3_e4_empty", 64'(b_valid), 64'd0);

        // Wrap-around stream 0..9, Depth=3
        rec_b.delete();
        for (int i = 0; i < 10; i++) send_b(32'(i));
        tick(6);
        chk("wrap_count", 64'(rec_b.size()), 64'd10);
        for (int i = 0; i < 10 && i < rec_b.size(); i++)
            chk($sformatf("wrap_item%0d", i), 64'(rec_b[i]), 64'(i));

        // Random back-pressure over 1000 items
        rec_b.delete();
        b_rnd = 1'b1;
        for (int i = 0; i < 1000; i++) send_b(32'h1000 + 32'(i));
        b_rnd = 1'b0;
        b_ready = 1'b1;
        tick(12);
        chk("rnd_count", 64'(rec_b.size()), 64'd1000);
        for (int i = 0; i < 1000 && i < rec_b.size(); i++)
            chk($sformatf("rnd_item%0d", i), 64'(rec_b[i]), 64'(32'h1000 + 32'(i)));
        chk("rnd_final_usage", 64'(b_usage), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdc_2phase_dst_fifo.md
# cdc_2phase_dst_fifo

Buffered receiver half of a two-phase (toggle) clock-domain-crossing handshake, running entirely in the destination clock domain. It synchronises the asynchronous request toggle through a configurable number of stages and captures the asynchronous data into a local FIFO of configurable depth. It acknowledges each item as soon as it is stored, not when the consumer takes it, so the remote sender can start its next transfer while the local consumer stalls. It pairs with the existing two-phase source half and replaces the unbuffered destination half wherever consumer back-pressure would otherwise throttle the crossing.

## Interface
Parameters:
- DataWidth, 32: width of the crossing payload.
- Depth, 2: number of FIFO entries. Must be ≥1 and need not be a power of two.
- SyncStages, 2: flip-flops in the request synchroniser. Must be ≥2.

Ports:
- clk_i  in  1  destination clock; the only clock of the block.
- rst_i  in  1  reset, asynchronous and active-high; clears all state.
- async_req_i  in  1  request toggle from the remote source; asynchronous.
- async_ack_o  out  1  acknowledge toggle to the remote source; driven directly from a register.
- async_data_i  in  DataWidth  payload from the remote source; held stable by the source from its request toggle until it sees the acknowledge.
- data_o  out  DataWidth  FIFO head.
- valid_o  out  1  FIFO is non-empty.
- ready_i  in  1  consumer accepts the head.
- usage_o  out  $clog2(Depth+1)  current number of stored items.

## Operation
- Synchroniser:
  - async_req_i → sync[0] → … → sync[SyncStages-1], called req_s.
  - All stages reset to 0.
  - No logic reads any stage other than req_s.
- Pending item: pending = (req_s != ack_q). ack_q drives async_ack_o.
- Capture, when pending && !full:
  - write async_data_i to mem[wptr];
  - advance wptr;
  - toggle ack_q.
- Pending while full: no capture. ack_q holds until an entry frees.
- No double capture: after the toggle, ack_q == req_s. The source cannot toggle again until it has seen the acknowledge.
- Pop: when valid_o && ready_i, advance rptr.
- Pointers: range 0..Depth-1 and wrap from Depth-1 to 0.
- Count update: +1 on push only, −1 on pop only, unchanged on push and pop together.
- Status signals:
  - full = (count == Depth), decided from the registered count;
  - a pop in the same cycle does not unblock a push (no full-bypass);
  - valid_o = (count != 0);
  - data_o = mem[rptr];
  - usage_o = count.
- Reset mid-operation:
  - all items are dropped;
  - pointers, count, ack_q and the synchroniser go to 0.
  - The remote source must be reset at the same time; spurious transfers are otherwise possible.
- Memory contents are not reset. data_o is forced to 0 while count == 0.

## Timing
- Reset values: async_ack_o=0, valid_o=0, data_o=0, usage_o=0.
- Latency:
  - async_req_i toggles before edge k;
  - req_s changes at edge k+SyncStages−1;
  - capture and ack toggle happen at edge k+SyncStages;
  - valid_o rises after edge k+SyncStages, i.e. SyncStages+1 edges after the toggle.
- Throughput: one item per remote round trip. The FIFO decouples the crossing from consumer stalls.
- data_o and valid_o are stable while valid_o && !ready_i.
- An empty FIFO does not pass through: a captured item is visible one cycle after capture, never in the same cycle.
- Max-delay constraint of one clk_i period applies to async_data_i → mem and to async_ack_o → remote.

## Test plan
- Single item, Depth=2, SyncStages=2, ready_i=1:
  - stimulus: async_data_i=0xA5A5_0001, toggle async_req_i before edge 0;
  - response: async_ack_o toggles at edge 2, valid_o=1 with data_o=0xA5A5_0001 after edge 2, valid_o=0 after edge 3.
- Back-pressure, Depth=2, ready_i=0:
  - stimulus: the source sends 3 items;
  - response: the first two are captured (usage_o=2) and acknowledged; the third stays pending with async_ack_o unchanged.
  - Then raise ready_i for one cycle: usage_o goes to 1. The third item is captured the next cycle (usage_o=2) and its ack toggles.
- Full with simultaneous pop:
  - stimulus: at count==Depth, ready_i=1 and a pending request;
  - response: the pop occurs and the push is deferred one cycle; the count sequence is 2→1→2.
- Wrap-around, Depth=3, ready_i=1:
  - stimulus: stream 10 items 0..9;
  - response: outputs appear in order 0..9, with wptr and rptr wrapping at 2→0.
- Reset mid-operation:
  - stimulus: assert rst_i with usage_o=2;
  - response: asynchronously valid_o=0, usage_o=0, async_ack_o=0, data_o=0.
  - After release, a fresh toggle from 0 is received correctly.
- SyncStages=3:
  - response: capture latency is 3 edges and valid_o rises 4 edges after the toggle.
  - Random ready_i over 1000 items gives no loss, no duplication and ordering preserved.
